// File: rtl/rr_arbiter_4.sv
// rr_arbiter_4 -- round-robin arbiter sharing one resource between 4 requesters.
//
// A grant is issued one clock after a request is seen in IDLE. It is held until
// the owner pulses rel, the owner drops its request, or the hold timer runs out.
// Every grant is followed by at least one idle cycle, which gives the bus time to
// turn around. Priority rotates from the last owner, so four continuous
// requesters share the resource fairly.
//
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   req      in   [3:0] request per requester, held while service is wanted
//   rel      in   release strobe from the current owner (looked at only in GRANT)
//   gnt      out  [3:0] registered one-hot grant, 0000 when idle
//   gnt_idx  out  [1:0] encoded grant index; keeps the last owner while idle
//   gnt_vld  out  high exactly when gnt != 0000
//   timeout  out  one-cycle pulse after a release forced by the hold timer
module rr_arbiter_4 #(
  parameter int HOLD_MAX = 16,  // max grant length in cycles, 0 = unlimited
  parameter int CNT_W    = 8    // hold counter width, HOLD_MAX < 2**CNT_W
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       rel,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_vld,
  output logic       timeout
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_e;

  // Counter value seen in the last allowed cycle of a grant.
  localparam logic [CNT_W-1:0] HOLD_LAST =
    (HOLD_MAX == 0) ? '0 : CNT_W'(HOLD_MAX - 1);

  state_e           state_q, state_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [1:0]       idx_q, idx_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [1:0]       last_ptr_q, last_ptr_d;

  logic       pick_vld;
  logic [1:0] pick_idx;
  logic [1:0] cand;
  logic       own_req;
  logic       at_limit;

  // Scan last_ptr+1 .. last_ptr+4. The 2-bit add wraps, so the last owner
  // is checked last.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = 2'd0;
    cand     = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      cand = last_ptr_q + 2'(i);
      if (!pick_vld && req[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  assign own_req  = req[idx_q];
  assign at_limit = (HOLD_MAX != 0) && (hold_cnt_q == HOLD_LAST);

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    idx_d      = idx_q;
    timeout_d  = 1'b0;
    hold_cnt_d = hold_cnt_q;
    last_ptr_d = last_ptr_q;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d    = GRANT;
          gnt_d      = 4'b0001 << pick_idx;
          idx_d      = pick_idx;
          hold_cnt_d = '0;
        end
      end
      GRANT: begin
        if (rel || !own_req || at_limit) begin
          state_d    = IDLE;
          gnt_d      = 4'b0000;
          last_ptr_d = idx_q;
          // The timer is flagged only when it is the sole release cause.
          timeout_d  = at_limit && !rel && own_req;
        end else if (hold_cnt_q != '1) begin
          // The counter saturates. This only matters when HOLD_MAX = 0.
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gnt_q      <= 4'b0000;
      idx_q      <= 2'd0;
      timeout_q  <= 1'b0;
      hold_cnt_q <= '0;
      last_ptr_q <= 2'd3;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      idx_q      <= idx_d;
      timeout_q  <= timeout_d;
      hold_cnt_q <= hold_cnt_d;
      last_ptr_q <= last_ptr_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_idx = idx_q;
  assign gnt_vld = |gnt_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Testbench for rr_arbiter_4. Directed scenarios plus a random run. Each
// cycle is compared with a cycle-count reference model of the arbiter.
module tb_rr_arbiter_4;
  localparam int HOLD = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic       rel = 1'b0;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_vld;
  logic       timeout;

  int n_vec = 0;
  int n_bad = 0;

  rr_arbiter_4 #(.HOLD_MAX(HOLD), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .rel(rel),
    .gnt(gnt), .gnt_idx(gnt_idx), .gnt_vld(gnt_vld), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Reference model. m_owner is -1 when nobody holds the grant. m_held
  // counts the grant cycles elapsed, including the current one.
  int m_owner = -1;
  int m_idx   = 0;
  int m_last  = 3;
  int m_held  = 0;
  bit m_to    = 1'b0;

  task automatic model_reset();
    m_owner = -1; m_idx = 0; m_last = 3; m_held = 0; m_to = 1'b0;
  endtask

  task automatic model_step();
    if (m_owner < 0) begin
      m_to = 1'b0;
      for (int k = 1; k <= 4; k++) begin
        int c = (m_last + k) % 4;
        if (m_owner < 0 && req[c]) begin
          m_owner = c; m_idx = c; m_held = 1;
        end
      end
    end else begin
      bit drop = !req[m_owner];
      bit lim  = (HOLD != 0) && (m_held == HOLD);
      if (rel || drop || lim) begin
        m_to = lim && !rel && !drop;
        m_last = m_owner;
        m_owner = -1;
      end else begin
        m_held++;
        m_to = 1'b0;
      end
    end
  endtask

  function automatic logic [7:0] exp_out();
    logic [3:0] g = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
    return {g, 2'(m_idx), (m_owner >= 0), m_to};
  endfunction

  // One clock. The model samples the same inputs as the DUT, and the caller
  // then looks at the outputs on the falling edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    req = 4'b0000; rel = 1'b0; rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_vec++;
    if ({gnt, gnt_idx, gnt_vld, timeout} !== 8'h00) begin
      n_bad++; $display("FAIL reset_state got=%b exp=%b", {gnt, gnt_idx, gnt_vld, timeout}, 8'h00);
    end
    rst_n = 1'b1;
    req = 4'b0100;
    tick();
    n_vec++;
    if (gnt !== 4'b0100) begin
      n_bad++; $display("FAIL reset_pre_grant got=%b exp=0100", gnt);
    end
    // Assert reset between clock edges. The grant has to clear at once.
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    n_vec++;
    if ({gnt, gnt_idx, gnt_vld, timeout} !== 8'h00) begin
      n_bad++; $display("FAIL reset_async got=%b exp=%b", {gnt, gnt_idx, gnt_vld, timeout}, 8'h00);
    end
    req = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    req = 4'b1111;
    tick();
    n_vec++;
    if (gnt !== 4'b0001 || gnt_idx !== 2'd0 || {gnt, gnt_idx, gnt_vld, timeout} !== exp_out()) begin
      n_bad++; $display("FAIL reset_first_grant got=%b/%0d exp=0001/0", gnt, gnt_idx);
    end
  endtask

  task automatic test_rotation();
    do_reset();
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      tick();
      n_vec++;
      if (gnt !== (4'b0001 << (g % 4)) || gnt_idx !== 2'(g % 4) || timeout !== 1'b0) begin
        n_bad++; $display("FAIL rotation_grant%0d got=%b/%0d exp idx=%0d", g, gnt, gnt_idx, g % 4);
      end
      tick();
      n_vec++;
      if ({gnt, gnt_idx, gnt_vld, timeout} !== exp_out() || gnt !== (4'b0001 << (g % 4))) begin
        n_bad++; $display("FAIL rotation_hold%0d got=%b exp=%b", g, {gnt, gnt_idx, gnt_vld, timeout}, exp_out());
      end
      rel = 1'b1;
      tick();
      rel = 1'b0;
      n_vec++;
      if (gnt !== 4'b0000 || gnt_vld !== 1'b0 || gnt_idx !== 2'(g % 4)) begin
        n_bad++; $display("FAIL rotation_idle%0d got=%b/%0d exp=0000/%0d", g, gnt, gnt_idx, g % 4);
      end
    end
  endtask

  task automatic test_timeout();
    do_reset();
    req = 4'b0100;
    for (int c = 0; c < HOLD; c++) begin
      tick();
      n_vec++;
      if (gnt !== 4'b0100 || timeout !== 1'b0 || {gnt, gnt_idx, gnt_vld, timeout} !== exp_out()) begin
        n_bad++; $display("FAIL timeout_hold_c%0d got=%b to=%b exp=0100 to=0", c, gnt, timeout);
      end
    end
    tick();
    n_vec++;
    if (gnt !== 4'b0000 || timeout !== 1'b1 || {gnt, gnt_idx, gnt_vld, timeout} !== exp_out()) begin
      n_bad++; $display("FAIL timeout_pulse got=%b to=%b exp=0000 to=1", gnt, timeout);
    end
    tick();
    n_vec++;
    if (gnt !== 4'b0100 || timeout !== 1'b0) begin
      n_bad++; $display("FAIL timeout_regrant got=%b to=%b exp=0100 to=0", gnt, timeout);
    end
  endtask

  task automatic test_priority();
    do_reset();
    req = 4'b0010;
    tick();
    req = 4'b1001;  // owner 1 drops its request, 3 and 0 wait
    tick();
    n_vec++;
    if (gnt !== 4'b0000 || gnt_idx !== 2'd1) begin
      n_bad++; $display("FAIL prio_release got=%b/%0d exp=0000/1", gnt, gnt_idx);
    end
    tick();
    n_vec++;
    if (gnt !== 4'b1000 || gnt_idx !== 2'd3 || {gnt, gnt_idx, gnt_vld, timeout} !== exp_out()) begin
      n_bad++; $display("FAIL prio_after1 got=%b/%0d exp=1000/3", gnt, gnt_idx);
    end
    rel = 1'b1;
    tick();
    rel = 1'b0;
    n_vec++;
    if (gnt !== 4'b0000 || gnt_idx !== 2'd3) begin
      n_bad++; $display("FAIL prio_idx_held got=%b/%0d exp=0000/3", gnt, gnt_idx);
    end
    tick();
    n_vec++;
    if (gnt !== 4'b0001 || gnt_idx !== 2'd0) begin
      n_bad++; $display("FAIL prio_wrap got=%b/%0d exp=0001/0", gnt, gnt_idx);
    end
  endtask

  task automatic test_rel_at_limit();
    do_reset();
    req = 4'b0001;
    for (int c = 0; c < HOLD; c++) tick();
    rel = 1'b1;  // issued in the final allowed cycle
    tick();
    rel = 1'b0;
    n_vec++;
    if (gnt !== 4'b0000 || timeout !== 1'b0 || {gnt, gnt_idx, gnt_vld, timeout} !== exp_out()) begin
      n_bad++; $display("FAIL rel_at_limit got=%b to=%b exp=0000 to=0", gnt, timeout);
    end
  endtask

  task automatic test_drop_req();
    do_reset();
    req = 4'b0011;
    tick();
    n_vec++;
    if (gnt !== 4'b0001) begin
      n_bad++; $display("FAIL drop_first got=%b exp=0001", gnt);
    end
    req = 4'b0010;
    tick();
    n_vec++;
    if (gnt !== 4'b0000 || timeout !== 1'b0) begin
      n_bad++; $display("FAIL drop_release got=%b to=%b exp=0000 to=0", gnt, timeout);
    end
    tick();
    n_vec++;
    if (gnt !== 4'b0010 || gnt_idx !== 2'd1) begin
      n_bad++; $display("FAIL drop_next got=%b/%0d exp=0010/1", gnt, gnt_idx);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 11) == 0) req[b] = ~req[b];
      rel = ($urandom_range(0, 24) == 0);
      tick();
      n_vec++;
      if ({gnt, gnt_idx, gnt_vld, timeout} !== exp_out()) begin
        n_bad++; $display("FAIL random_c%0d got=%b exp=%b req=%b", c, {gnt, gnt_idx, gnt_vld, timeout}, exp_out(), req);
      end
    end
    rel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_timeout();
    test_priority();
    test_rel_at_limit();
    test_drop_req();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
